// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez program memory, CPU and UART program loader.
// Holds the memory geometry defaults and the loader's state encoding.
package simplez_pkg;

  localparam int SIMPLEZ_AW = 9;
  localparam int SIMPLEZ_DW = 12;

  // Frame start marker, ASCII 'L'.
  localparam logic [7:0] LOADER_START = 8'h4C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_W_LO,
    S_W_HI,
    S_CSUM,
    S_DONE,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/uart_prog_loader.sv
// Loads a framed program from the UART byte stream into Simplez memory,
// verifies its XOR checksum, and releases the CPU reset only after a clean load.
module uart_prog_loader
  import simplez_pkg::*;
#(
  parameter int         AW         = SIMPLEZ_AW,
  parameter int         DW         = SIMPLEZ_DW,
  parameter int         BASE_ADDR  = 0,
  parameter logic [7:0] START_BYTE = LOADER_START
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_rstn
);

  // Largest word count that still fits between BASE_ADDR and the top of memory.
  localparam logic [16:0] MAX_WORDS = 17'((1 << AW) - BASE_ADDR);

  loader_state_t state;
  logic [7:0]    cnt_lo;
  logic [7:0]    lo;
  logic [7:0]    xor_acc;
  logic [15:0]   remaining;
  logic [16:0]   count;

  assign count = {1'b0, rx_data, cnt_lo};

  // NOTE: every register here is sequential state and uses <=; where two
  // assignments land on the same edge, the later one in this block wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt_lo    <= '0;
      lo        <= '0;
      xor_acc   <= '0;
      remaining <= '0;
      mem_addr  <= AW'(BASE_ADDR);
      mem_wr    <= 1'b0;
      mem_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rstn  <= 1'b0;
    end else begin
      // Write pulse lasts one cycle; the address advances as it drops.
      if (mem_wr) begin
        mem_wr   <= 1'b0;
        mem_addr <= mem_addr + AW'(1);
      end

      if (rx_valid) begin
        unique case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (rx_data == START_BYTE) begin
              state    <= S_CNT_LO;
              xor_acc  <= '0;
              mem_addr <= AW'(BASE_ADDR);
              busy     <= 1'b1;
              done     <= 1'b0;
              error    <= 1'b0;
              cpu_rstn <= 1'b0;
            end
          end

          S_CNT_LO: begin
            cnt_lo  <= rx_data;
            xor_acc <= xor_acc ^ rx_data;
            state   <= S_CNT_HI;
          end

          S_CNT_HI: begin
            xor_acc <= xor_acc ^ rx_data;
            if (count == '0 || count > MAX_WORDS) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              remaining <= count[15:0];
              state     <= S_W_LO;
            end
          end

          S_W_LO: begin
            lo      <= rx_data;
            xor_acc <= xor_acc ^ rx_data;
            state   <= S_W_HI;
          end

          S_W_HI: begin
            if (rx_data[7:4] != 4'h0) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              xor_acc   <= xor_acc ^ rx_data;
              mem_data  <= DW'({rx_data[3:0], lo});
              mem_wr    <= 1'b1;
              remaining <= remaining - 16'd1;
              state     <= (remaining > 16'd1) ? S_W_LO : S_CSUM;
            end
          end

          S_CSUM: begin
            busy <= 1'b0;
            if (rx_data == xor_acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_rstn <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: frames are driven byte by byte and a
// negedge monitor mirrors every memory write into a local model.
module tb_uart_prog_loader;
  import simplez_pkg::*;

  localparam int AW = 9;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_data;
  logic          busy, done, error, cpu_rstn;
  logic [3:0]    st;

  assign st = {busy, done, error, cpu_rstn};

  uart_prog_loader dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .mem_addr (mem_addr),
    .mem_wr   (mem_wr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_rstn (cpu_rstn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [512];
  int   wr_count = 0;
  int   last_addr = -1;
  int   seq_err = 0;
  int   long_pulse = 0;
  logic prev_wr = 1'b0;
  logic [7:0] fq [$];

  // Memory samples on the negedge inside the write pulse.
  always @(negedge clk) begin
    if (mem_wr) begin
      mem[mem_addr] = mem_data;
      if (int'(mem_addr) != wr_count) seq_err++;
      last_addr = int'(mem_addr);
      wr_count++;
      if (prev_wr) long_pulse++;
    end
    prev_wr = mem_wr;
  end

  task automatic clear_model();
    for (int i = 0; i < 512; i++) mem[i] = 12'hAAA;
    wr_count   = 0;
    last_addr  = -1;
    seq_err    = 0;
    long_pulse = 0;
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  // One byte with a gap after it; returns just past the negedge following its edge.
  task automatic put1(input logic [7:0] b);
    put(b);
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
  endtask

  task automatic send_fq(input bit gap);
    for (int i = 0; i < fq.size(); i++) begin
      if (gap) put1(fq[i]);
      else     put(fq[i]);
    end
    if (!gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (st !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp %b", st, 4'b0000); end
    checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_addr); end
    checks++; if ({mem_wr, mem_data} !== 13'h0) begin errors++; $display("FAIL reset_wr_data got %b/%h exp 0/000", mem_wr, mem_data); end
    @(negedge clk);
    rstn = 1'b1;
    // Partial frame, then abort while the first write pulse is high.
    put(8'h4C); put(8'h02); put(8'h00); put(8'h03); put(8'h0E);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++; if ({busy, mem_wr} !== 2'b11) begin errors++; $display("FAIL midframe_busy_wr got %b exp 11", {busy, mem_wr}); end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({st, mem_wr, mem_data, mem_addr} !== {4'b0000, 1'b0, 12'h000, 9'd0})
      begin errors++; $display("FAIL async_reset got st=%b wr=%b data=%h addr=%0d exp all zero", st, mem_wr, mem_data, mem_addr); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Bytes after 4C: 02^00^03^0E^00^07 = 08; words {E,03}=E03 (o7003), {7,00}=700.
  task automatic test_good_frame();
    clear_model();
    fq = '{8'h4C, 8'h02, 8'h00, 8'h03, 8'h0E, 8'h00, 8'h07, 8'h08};
    send_fq(1'b1);
    checks++; if (wr_count !== 2) begin errors++; $display("FAIL good_writes got %0d exp 2", wr_count); end
    checks++; if ({mem[0], mem[1]} !== {12'hE03, 12'h700}) begin errors++; $display("FAIL good_mem got %h %h exp e03 700", mem[0], mem[1]); end
    checks++; if (st !== 4'b0101) begin errors++; $display("FAIL good_status got %b exp 0101", st); end
    checks++; if (long_pulse !== 0 || seq_err !== 0) begin errors++; $display("FAIL good_pulses got long=%0d seq=%0d exp 0 0", long_pulse, seq_err); end
  endtask

  task automatic test_bad_csum();
    clear_model();
    fq = '{8'h4C, 8'h02, 8'h00, 8'h03, 8'h0E, 8'h00, 8'h07, 8'h00};
    send_fq(1'b1);
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL badcsum_status got %b exp 0010", st); end
    checks++; if (wr_count !== 2 || mem[0] !== 12'hE03 || mem[1] !== 12'h700)
      begin errors++; $display("FAIL badcsum_mem got n=%0d %h %h exp 2 e03 700", wr_count, mem[0], mem[1]); end
  endtask

  task automatic test_high_nibble();
    clear_model();
    put1(8'h4C); put1(8'h01); put1(8'h00); put1(8'h05);
    checks++; if (st !== 4'b1000) begin errors++; $display("FAIL nibble_pre_status got %b exp 1000", st); end
    put1(8'hF0);
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL nibble_status got %b exp 0010", st); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL nibble_writes got %0d exp 0", wr_count); end
  endtask

  task automatic test_count_limits();
    logic [7:0] x;
    logic [8:0] idx;
    int bad;
    clear_model();
    put1(8'h4C);
    checks++; if (st !== 4'b1000) begin errors++; $display("FAIL n0_start_status got %b exp 1000", st); end
    put1(8'h00); put1(8'h00);
    checks++; if (st !== 4'b0010 || wr_count !== 0) begin errors++; $display("FAIL n0 got st=%b n=%0d exp 0010 0", st, wr_count); end
    put1(8'h4C); put1(8'h01);
    checks++; if (st !== 4'b1000) begin errors++; $display("FAIL n513_mid_status got %b exp 1000", st); end
    put1(8'h02);
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL n513_status got %b exp 0010", st); end

    // N=512: word i = i, sent back to back.
    clear_model();
    fq = '{8'h4C, 8'h00, 8'h02};
    x = 8'h02;
    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      fq.push_back(idx[7:0]);
      fq.push_back({7'b0, idx[8]});
      x = x ^ idx[7:0] ^ {7'b0, idx[8]};
    end
    fq.push_back(x);
    send_fq(1'b0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== 12'(i)) bad++;
    checks++; if (wr_count !== 512 || last_addr !== 511) begin errors++; $display("FAIL n512_writes got n=%0d last=%0d exp 512 511", wr_count, last_addr); end
    checks++; if (bad !== 0 || seq_err !== 0) begin errors++; $display("FAIL n512_mem got bad=%0d seq=%0d exp 0 0", bad, seq_err); end
    checks++; if (st !== 4'b0101) begin errors++; $display("FAIL n512_status got %b exp 0101", st); end
  endtask

  // Bytes after 4C: 03^00^21^05^FF^0F^00^00 = D7; words 521, FFF, 000.
  task automatic test_back_to_back();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    clear_model();
    fq = '{8'h00, 8'h55, 8'hFF, 8'h4B};
    send_fq(1'b0);
    checks++; if (st !== 4'b0000 || mem_addr !== 9'd0 || wr_count !== 0)
      begin errors++; $display("FAIL junk_idle got st=%b addr=%0d n=%0d exp 0000 0 0", st, mem_addr, wr_count); end
    fq = '{8'h4C, 8'h03, 8'h00, 8'h21, 8'h05, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hD7};
    send_fq(1'b0);
    checks++; if (wr_count !== 3 || {mem[0], mem[1], mem[2]} !== {12'h521, 12'hFFF, 12'h000})
      begin errors++; $display("FAIL b2b_mem got n=%0d %h %h %h exp 3 521 fff 000", wr_count, mem[0], mem[1], mem[2]); end
    checks++; if (st !== 4'b0101 || seq_err !== 0 || long_pulse !== 0)
      begin errors++; $display("FAIL b2b_status got st=%b seq=%0d long=%0d exp 0101 0 0", st, seq_err, long_pulse); end
    put1(8'h4C);
    checks++; if (st !== 4'b1000) begin errors++; $display("FAIL restart_status got %b exp 1000", st); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_high_nibble();
    test_count_limits();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
